key_tick_gen: RTL and testbench

- Conditions a raw asynchronous push-button level into clean single-cycle enable pulses.
- Sits directly upstream of the modulo-M counter: `tick_o` drives the counter's `en` input.
- Provides synchronisation, debounce, press/release edge pulses and hold-to-auto-repeat, so a held key steps the counter at a controlled rate.

---
 rtl/key_tick_gen.sv | 172 +++++++++++++++++
 tb/tb_key_tick_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/key_tick_gen.sv
// Push-button conditioner: synchroniser, debounce, press/release pulses and a step tick.
// Optional macro KEY_TICK_AUTOREPEAT_EN adds hold-to-auto-repeat ticks (HOLD/REPEAT states).
//
//  state  | meaning
//  IDLE   | key released, waiting for a debounced press
//  HOLD   | key pressed, timing the initial repeat delay (or just held, without repeat)
//  REPEAT | key held past the delay, issuing periodic repeat ticks
module key_tick_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYC     = 20,
    parameter int REP_DLY     = 500,
    parameter int REP_PER     = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic tick_o,
    output logic repeat_o
);

    localparam int DEB_W = $clog2(DEB_CYC + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   tick_q, tick_d;
    logic                   s;

    // Level flips only after the mismatch has been counted through DEB_CYC cycles;
    // any cycle where s agrees with the level restarts the count.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], key_i};
        s         = sync_q[SYNC_STAGES-1];
        deb_cnt_d = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s != level_q) begin
            if (deb_cnt_q == DEB_W'(DEB_CYC)) begin
                level_d   = s;
                press_d   = s;
                release_d = ~s;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

`ifdef KEY_TICK_AUTOREPEAT_EN
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    localparam int REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int REP_W   = $clog2(REP_MAX);

    state_t           state_q, state_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             repeat_q, repeat_d;

    // Release is checked first so it suppresses a repeat tick due on the same edge.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        repeat_d  = repeat_q;
        tick_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_d) begin
                    state_d   = HOLD;
                    tick_d    = 1'b1;
                    rep_cnt_d = '0;
                    repeat_d  = 1'b0;
                end
            end
            HOLD: begin
                if (release_d) begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                    repeat_d  = 1'b0;
                end else if (rep_cnt_q == REP_W'(REP_DLY - 1)) begin
                    state_d   = REPEAT;
                    tick_d    = 1'b1;
                    repeat_d  = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
            end
            REPEAT: begin
                if (release_d) begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                    repeat_d  = 1'b0;
                end else if (rep_cnt_q == REP_W'(REP_PER - 1)) begin
                    tick_d    = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                rep_cnt_d = '0;
                repeat_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rep_cnt_q <= '0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
            repeat_q  <= repeat_d;
        end
    end

    assign repeat_o = repeat_q;
`else
    typedef enum logic {IDLE, HOLD} state_t;

    state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        tick_d  = press_d;
        case (state_q)
            IDLE:    if (press_d)   state_d = HOLD;
            HOLD:    if (release_d) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign repeat_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            tick_q    <= tick_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign tick_o    = tick_q;

endmodule

// File: tb/tb_key_tick_gen.sv
// Scoreboard bench for key_tick_gen (SYNC_STAGES=2, DEB_CYC=4, REP_DLY=10, REP_PER=3).
// Expectations follow KEY_TICK_AUTOREPEAT_EN in the same way the design does.
module tb_key_tick_gen;

`ifdef KEY_TICK_AUTOREPEAT_EN
    localparam bit AR   = 1'b1;
    localparam int DROP = 30;
`else
    localparam bit AR   = 1'b0;
    localparam int DROP = 50;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_i = 1'b0;
    logic level_o, press_o, release_o, tick_o, repeat_o;

    key_tick_gen #(
        .SYNC_STAGES(2),
        .DEB_CYC    (4),
        .REP_DLY    (10),
        .REP_PER    (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_i    (key_i),
        .level_o  (level_o),
        .press_o  (press_o),
        .release_o(release_o),
        .tick_o   (tick_o),
        .repeat_o (repeat_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int   c;
        logic p;
        logic r;
        logic t;
        logic rp;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    ev_t mon_got;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  base  = 0;

    task automatic push_ev(input int e, input logic p, input logic r, input logic t, input logic rp);
        ev_t ev;
        ev.c  = base + e;
        ev.p  = p;
        ev.r  = r;
        ev.t  = t;
        ev.rp = rp;
        exp_q.push_back(ev);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc - base);
        end
    endtask

    task automatic step_to(input int e);
        while (cyc < base + e) @(negedge clk);
    endtask

    task automatic start_press();
        base  = cyc + 1;
        key_i = 1'b1;
    endtask

    // Monitor: every output pulse must match the next expected event.
    always @(negedge clk) begin
        if (press_o || release_o || tick_o) begin
            mon_got.c  = cyc;
            mon_got.p  = press_o;
            mon_got.r  = release_o;
            mon_got.t  = tick_o;
            mon_got.rp = repeat_o;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: got edge=%0d p=%0b r=%0b t=%0b rep=%0b, required no pulse",
                         cyc - base, press_o, release_o, tick_o, repeat_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_got !== mon_e) begin
                    n_bad++;
                    $display("FAIL event: got edge=%0d p=%0b r=%0b t=%0b rep=%0b, required edge=%0d p=%0b r=%0b t=%0b rep=%0b",
                             mon_got.c - base, mon_got.p, mon_got.r, mon_got.t, mon_got.rp,
                             mon_e.c - base, mon_e.p, mon_e.r, mon_e.t, mon_e.rp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {level_o, press_o, release_o, tick_o, repeat_o}, 5'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press, held, then released
        start_press();
        push_ev(6, 1'b1, 1'b0, 1'b1, 1'b0);
        if (AR) begin
            for (int e = 16; e <= 34; e += 3) push_ev(e, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        push_ev(DROP + 6, 1'b0, 1'b1, 1'b0, 1'b0);
        step_to(5);
        check("level_before_press", level_o, 1'b0);
        step_to(15);
        check("repeat_in_hold", repeat_o, 1'b0);
        check("level_held", level_o, 1'b1);
        step_to(16);
        check("tick_e16", tick_o, AR);
        step_to(17);
        check("repeat_e17", repeat_o, AR);
        check("tick_e17", tick_o, 1'b0);
        step_to(DROP - 1);
        key_i = 1'b0;
        step_to(DROP + 10);
        check("level_after_release", level_o, 1'b0);
        check("repeat_after_release", repeat_o, 1'b0);

        // Bounce: toggles every 2 cycles, never settles long enough
        base = cyc + 1;
        for (int i = 0; i < 20; i++) begin
            key_i = ((i / 2) % 2) == 0;
            @(negedge clk);
        end
        key_i = 1'b0;
        repeat (15) @(negedge clk);
        check("bounce_level", level_o, 1'b0);

        // Release lands on the edge a repeat tick was due
        start_press();
        push_ev(6, 1'b1, 1'b0, 1'b1, 1'b0);
        if (AR) begin
            push_ev(16, 1'b0, 1'b0, 1'b1, 1'b1);
            push_ev(19, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        push_ev(22, 1'b0, 1'b1, 1'b0, 1'b0);
        step_to(15);
        key_i = 1'b0;
        step_to(22);
        check("collision_tick", tick_o, 1'b0);
        check("collision_release", release_o, 1'b1);
        step_to(30);

        // Asynchronous reset while repeating, key still held
        start_press();
        push_ev(6, 1'b1, 1'b0, 1'b1, 1'b0);
        if (AR) begin
            push_ev(16, 1'b0, 1'b0, 1'b1, 1'b1);
            push_ev(19, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        step_to(20);
        check("pre_reset_level", level_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {level_o, press_o, release_o, tick_o, repeat_o}, 5'b0);
        step_to(24);
        rst_n = 1'b1;
        push_ev(31, 1'b1, 1'b0, 1'b1, 1'b0);
        push_ev(39, 1'b0, 1'b1, 1'b0, 1'b0);
        step_to(30);
        check("post_reset_level_e30", level_o, 1'b0);
        step_to(32);
        key_i = 1'b0;
        step_to(45);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
